player_multi_shot_block: RTL and testbench

Parametrised player-fire block that manages up to MAX_SHOTS independent shots in flight. It launches shots from the player cannon on fire requests and enforces a frame-based cooldown. Each frame it moves live shots upward, retires them on collision or at the top of the screen, and renders all live shots into one drawing request and RGB stream. It sits in the player path alongside the player movement block, and its outputs feed the screen mux and the collision detector.

---
 rtl/player_multi_shot_block.sv | 184 ++++++++++++++++++
 tb/tb_player_multi_shot_block.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/player_multi_shot_block.sv
// Player fire block: keeps up to MAX_SHOTS shots in flight, launches them on fire
// requests behind a frame cooldown, moves and retires them each frame, and draws them.
module player_multi_shot_block #(
    parameter int          MAX_SHOTS       = 3,
    parameter int          SHOT_WIDTH      = 2,
    parameter int          SHOT_HEIGHT     = 16,
    parameter int          SHOT_SPEED      = 4,
    parameter int          COOLDOWN_FRAMES = 8,
    parameter int          LAUNCH_Y        = 448,
    parameter int          PLAYER_WIDTH    = 32,
    parameter int          TOP_LIMIT       = 16,
    parameter logic [7:0]  SHOT_COLOR      = 8'hFF
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic                 startOfFrame,
    input  logic                 fireCollision,
    input  logic [10:0]          playerXPosition,
    input  logic                 keyRisingEdge,
    input  logic                 standBy,
    input  logic                 gameEnded,
    output logic [7:0]           playerShotRGB,
    output logic                 playerShotDR,
    output logic [MAX_SHOTS-1:0] aliveMask,
    output logic [3:0]           shotsInFlight,
    output logic                 newFire,
    output logic                 cooldownBusy
);

    localparam int          CW       = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int          SW       = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
    localparam logic [10:0] KILL_Y   = 11'(TOP_LIMIT + SHOT_SPEED);
    localparam logic [10:0] SPEED    = 11'(SHOT_SPEED);
    localparam logic [10:0] START_Y  = 11'(LAUNCH_Y);
    localparam logic [10:0] X_OFFSET = 11'(PLAYER_WIDTH / 2 - SHOT_WIDTH / 2);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_FRAMES);

    logic                 playGame;
    logic [MAX_SHOTS-1:0] alive, aliveNext;
    logic [MAX_SHOTS-1:0] hitPending, hitNext;
    logic [10:0]          shotX [MAX_SHOTS];
    logic [10:0]          shotY [MAX_SHOTS];
    logic [10:0]          xNext [MAX_SHOTS];
    logic [10:0]          yNext [MAX_SHOTS];
    logic                 firePending, fireNext;
    logic [CW-1:0]        cooldown, coolNext;
    logic                 spawn, freeFound;
    logic [SW-1:0]        spawnIdx;
    logic [SW-1:0]        drawSlot, hitIdx;
    logic                 hitAny;
    logic [MAX_SHOTS-1:0] slotHit;

    assign playGame     = ~(standBy | gameEnded);
    assign aliveMask    = alive;
    assign cooldownBusy = (cooldown != '0);

    // Frame update: kill, move, spawn into the lowest free slot, then cooldown.
    // A fire pulse arriving with startOfFrame is folded into fireNext so it is serviced now.
    always_comb begin
        aliveNext = alive;
        hitNext   = hitPending;
        xNext     = shotX;
        yNext     = shotY;
        fireNext  = firePending | keyRisingEdge;
        coolNext  = cooldown;
        spawn     = 1'b0;
        freeFound = 1'b0;
        spawnIdx  = '0;

        if (fireCollision && playerShotDR) begin
            hitNext[drawSlot] = 1'b1;
        end

        if (startOfFrame) begin
            for (int i = 0; i < MAX_SHOTS; i++) begin
                if (alive[i] && !hitPending[i] && shotY[i] >= KILL_Y) begin
                    yNext[i] = shotY[i] - SPEED;
                end else begin
                    aliveNext[i] = 1'b0;
                    hitNext[i]   = 1'b0;
                end
            end

            for (int i = 0; i < MAX_SHOTS; i++) begin
                if (!aliveNext[i] && !freeFound) begin
                    freeFound = 1'b1;
                    spawnIdx  = SW'(i);
                end
            end

            if (fireNext && playGame && cooldown == '0 && freeFound) begin
                spawn               = 1'b1;
                aliveNext[spawnIdx] = 1'b1;
                hitNext[spawnIdx]   = 1'b0;
                xNext[spawnIdx]     = playerXPosition + X_OFFSET;
                yNext[spawnIdx]     = START_Y;
                coolNext            = COOL_LOAD;
            end else if (cooldown != '0) begin
                coolNext = cooldown - CW'(1);
            end

            fireNext = 1'b0;
        end

        if (!playGame) begin
            aliveNext = '0;
            hitNext   = '0;
            fireNext  = 1'b0;
            coolNext  = '0;
            spawn     = 1'b0;
        end
    end

    // Compare in 12 bits so a shot near the right/bottom edge cannot wrap its extent.
    always_comb begin
        slotHit = '0;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            slotHit[i] = alive[i]
                && ({1'b0, pixelX} >= {1'b0, shotX[i]})
                && ({1'b0, pixelX} <  {1'b0, shotX[i]} + 12'(SHOT_WIDTH))
                && ({1'b0, pixelY} >= {1'b0, shotY[i]})
                && ({1'b0, pixelY} <  {1'b0, shotY[i]} + 12'(SHOT_HEIGHT));
        end
    end

    always_comb begin
        hitAny = 1'b0;
        hitIdx = '0;
        for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
            if (slotHit[i]) begin
                hitAny = 1'b1;
                hitIdx = SW'(i);
            end
        end
    end

    always_comb begin
        shotsInFlight = '0;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            if (alive[i]) begin
                shotsInFlight = shotsInFlight + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            alive       <= '0;
            hitPending  <= '0;
            firePending <= 1'b0;
            cooldown    <= '0;
            for (int i = 0; i < MAX_SHOTS; i++) begin
                shotX[i] <= '0;
                shotY[i] <= '0;
            end
        end else begin
            alive       <= aliveNext;
            hitPending  <= hitNext;
            firePending <= fireNext;
            cooldown    <= coolNext;
            for (int i = 0; i < MAX_SHOTS; i++) begin
                shotX[i] <= xNext[i];
                shotY[i] <= yNext[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            playerShotDR  <= 1'b0;
            playerShotRGB <= 8'h00;
            drawSlot      <= '0;
            newFire       <= 1'b0;
        end else begin
            playerShotDR  <= hitAny & playGame;
            playerShotRGB <= (hitAny && playGame) ? SHOT_COLOR : 8'h00;
            drawSlot      <= hitIdx;
            newFire       <= spawn;
        end
    end

endmodule

// File: tb/tb_player_multi_shot_block.sv
// Directed bench for player_multi_shot_block: one instance with the default cooldown
// and one with no cooldown, sharing all inputs.
module tb_player_multi_shot_block;

    localparam logic [10:0] IDLE = 11'h7FF;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY, playerXPosition;
    logic        startOfFrame, fireCollision, keyRisingEdge, standBy, gameEnded;

    logic [7:0]  rgbA, rgbB;
    logic        drA, drB, newFireA, newFireB, busyA, busyB;
    logic [2:0]  aliveA, aliveB;
    logic [3:0]  shotsA, shotsB;

    int errors = 0;
    int checks = 0;
    int drSeen = 0;

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic        expDr;
        logic [7:0]  expRgb;
    } drawVec_t;

    drawVec_t drawVecs [8];

    always #5 clk = ~clk;

    player_multi_shot_block dutA (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .fireCollision(fireCollision),
        .playerXPosition(playerXPosition), .keyRisingEdge(keyRisingEdge),
        .standBy(standBy), .gameEnded(gameEnded),
        .playerShotRGB(rgbA), .playerShotDR(drA), .aliveMask(aliveA),
        .shotsInFlight(shotsA), .newFire(newFireA), .cooldownBusy(busyA)
    );

    player_multi_shot_block #(.COOLDOWN_FRAMES(0)) dutB (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .fireCollision(fireCollision),
        .playerXPosition(playerXPosition), .keyRisingEdge(keyRisingEdge),
        .standBy(standBy), .gameEnded(gameEnded),
        .playerShotRGB(rgbB), .playerShotDR(drB), .aliveMask(aliveB),
        .shotsInFlight(shotsB), .newFire(newFireB), .cooldownBusy(busyB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drives one clock of inputs; pulse inputs drop back to 0 afterwards.
    task automatic applyStimulus(input logic sof, input logic key, input logic col,
                                 input logic [10:0] px, input logic [10:0] py);
        startOfFrame  = sof;
        keyRisingEdge = key;
        fireCollision = col;
        pixelX        = px;
        pixelY        = py;
        @(posedge clk);
        #1;
        startOfFrame  = 1'b0;
        keyRisingEdge = 1'b0;
        fireCollision = 1'b0;
        if (drA || drB) drSeen++;
    endtask

    task automatic doFrame(input logic press);
        applyStimulus(1'b1, press, 1'b0, IDLE, IDLE);
    endtask

    task automatic padClock();
        applyStimulus(1'b0, 1'b0, 1'b0, IDLE, IDLE);
    endtask

    task automatic doReset();
        resetN = 1'b0;
        standBy = 1'b0;
        gameEnded = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        padClock();
    endtask

    initial begin
        drawVecs[0] = '{11'd115, 11'd444, 1'b1, 8'hFF};
        drawVecs[1] = '{11'd116, 11'd444, 1'b1, 8'hFF};
        drawVecs[2] = '{11'd117, 11'd444, 1'b0, 8'h00};
        drawVecs[3] = '{11'd114, 11'd444, 1'b0, 8'h00};
        drawVecs[4] = '{11'd115, 11'd459, 1'b1, 8'hFF};
        drawVecs[5] = '{11'd116, 11'd460, 1'b0, 8'h00};
        drawVecs[6] = '{11'd116, 11'd443, 1'b0, 8'h00};
        drawVecs[7] = '{11'd116, 11'd452, 1'b1, 8'hFF};

        resetN = 1'b0;
        pixelX = IDLE;
        pixelY = IDLE;
        playerXPosition = 11'd100;
        startOfFrame = 1'b0;
        fireCollision = 1'b0;
        keyRisingEdge = 1'b0;
        standBy = 1'b0;
        gameEnded = 1'b0;
        #12;
        checkOutput("resetDR", drA, 0);
        checkOutput("resetRGB", rgbA, 0);
        checkOutput("resetAlive", aliveA, 0);
        checkOutput("resetShots", shotsA, 0);
        checkOutput("resetNewFire", newFireA, 0);
        checkOutput("resetBusy", busyA, 0);
        doReset();

        // Idle frames: nothing launches or draws.
        drSeen = 0;
        for (int f = 0; f < 3; f++) begin
            doFrame(1'b0);
            checkOutput("idleNewFire", newFireA, 0);
            applyStimulus(1'b0, 1'b0, 1'b0, 11'd115, 11'd448);
            padClock();
        end
        checkOutput("idleAlive", aliveA, 0);
        checkOutput("idleDrSeen", drSeen, 0);

        // Single launch and drawing geometry.
        doFrame(1'b1);
        checkOutput("launchNewFire", newFireA, 1);
        checkOutput("launchAlive", aliveA, 3'b001);
        checkOutput("launchShots", shotsA, 1);
        checkOutput("launchBusy", busyA, 1);
        padClock();
        checkOutput("newFireOneClock", newFireA, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd115, 11'd448);
        checkOutput("launchY448", drA, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd115, 11'd447);
        checkOutput("launchY447", drA, 0);
        doFrame(1'b0);
        padClock();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, drawVecs[i].px, drawVecs[i].py);
            checkOutput($sformatf("drawDR[%0d]", i), drA, drawVecs[i].expDr);
            checkOutput($sformatf("drawRGB[%0d]", i), rgbA, drawVecs[i].expRgb);
        end

        // Cooldown of 8: launches every 9th frame while pressing each frame.
        doReset();
        for (int k = 0; k < 19; k++) begin
            doFrame(1'b1);
            checkOutput($sformatf("coolNewFire[%0d]", k), newFireA, (k % 9) == 0);
            checkOutput($sformatf("coolBusy[%0d]", k), busyA, (k % 9) != 8);
            padClock();
        end
        checkOutput("coolShots", shotsA, 3);

        // No cooldown: fill all slots, then slot0 retires at the top and respawns.
        doReset();
        for (int k = 0; k <= 110; k++) begin
            doFrame(k <= 109);
            checkOutput($sformatf("fillNewFire[%0d]", k), newFireB, (k < 3) || (k == 109));
            checkOutput($sformatf("fillShots[%0d]", k), shotsB,
                        (k >= 110) ? 2 : ((k < 3) ? k + 1 : 3));
            checkOutput($sformatf("fillBusyB[%0d]", k), busyB, 0);
        end
        checkOutput("respawnAlive", aliveB, 3'b101);

        // Collision on slot1 only; slot0 keeps moving.
        doReset();
        doFrame(1'b1);
        padClock();
        doFrame(1'b1);
        padClock();
        checkOutput("colPreAlive", aliveB, 3'b011);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd115, 11'd461);
        checkOutput("colSlot1Drawn", drB, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, IDLE, IDLE);
        checkOutput("colStillVisible", aliveB, 3'b011);
        doFrame(1'b0);
        checkOutput("colRetired", aliveB, 3'b001);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd115, 11'd440);
        checkOutput("colSlot0Moved", drB, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd115, 11'd439);
        checkOutput("colSlot0Above", drB, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd115, 11'd457);
        checkOutput("colSlot1Gone", drB, 0);

        // Game halt clears everything; presses in standby are ignored.
        checkOutput("haltPreAlive", aliveA, 3'b001);
        gameEnded = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 11'd115, 11'd440);
        checkOutput("haltAliveA", aliveA, 0);
        checkOutput("haltAliveB", aliveB, 0);
        checkOutput("haltDrA", drA, 0);
        checkOutput("haltShotsA", shotsA, 0);
        checkOutput("haltBusyA", busyA, 0);
        gameEnded = 1'b0;
        standBy = 1'b1;
        doFrame(1'b1);
        checkOutput("standByNewFireA", newFireA, 0);
        checkOutput("standByNewFireB", newFireB, 0);
        checkOutput("standByAlive", aliveA, 0);
        padClock();
        standBy = 1'b0;
        doFrame(1'b1);
        checkOutput("resumeNewFire", newFireA, 1);
        checkOutput("resumeAlive", aliveA, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
